// File: rtl/evg_pkg.sv
// Shared constants and helpers for the EVG event-slot arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package evg_pkg;

    localparam int        EVENT_CODE_WIDTH = 8;
    localparam logic [7:0] K28_5           = 8'hBC;
    localparam logic [7:0] NULL_EVENT      = 8'h00;

    // Index width for n items, never narrower than one bit so that
    // single-bit selects still have a real port.
    function automatic int evg_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evg_rr_arbiter.sv
// Round-robin pick over requesters 1..N-1 (bit k-1 of i_req is port k).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller owns the pointer and decides whether to use the grant.
// Ports: i_req  - request vector for ports 1..N-1
//        i_ptr  - port number (1..N-1) to search from, upward with wrap
//        o_grant- one-hot grant aligned with i_req
//        o_idx  - port number (1..N-1) of the winner
//        o_vld  - a winner exists
module evg_rr_arbiter
    import evg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-2:0]                  i_req,
    input  logic [evg_idx_width(N)-1:0]   i_ptr,
    output logic [N-2:0]                  o_grant,
    output logic [evg_idx_width(N)-1:0]   o_idx,
    output logic                          o_vld
);

    localparam int IDX_W = evg_idx_width(N);

    // Bit position inside i_req examined at search step 'off'.
    // An out-of-range pointer falls back to searching from port 1.
    function automatic int rr_slot(input logic [IDX_W-1:0] ptr, input int off);
        int base;
        base = 0;
        if (int'(ptr) >= 1 && int'(ptr) <= N-1)
            base = int'(ptr) - 1;
        return (base + off) % (N-1);
    endfunction

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_vld   = 1'b0;
        for (int off = 0; off < N-1; off++) begin
            if (!o_vld && i_req[rr_slot(i_ptr, off)]) begin
                o_vld                           = 1'b1;
                o_grant[rr_slot(i_ptr, off)]    = 1'b1;
                o_idx                           = IDX_W'(rr_slot(i_ptr, off) + 1);
            end
        end
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// Per-cycle event-byte scheduler: port 0 strict priority, ports 1..N-1 round-robin, forced K28.5 comma every COMMA_INTERVAL cycles.
// Latency: 1 cycle from accepted request (Ready high) to evgEventCode/evgGrantValid.
// Backpressure: Ready is a one-hot same-cycle grant; unserved sources hold Valid/Code and are counted as collisions.
// Ports: evgTxClk/evgTxReset clock and async active-high reset; evgRequest{Enable,Valid,Code} in,
//        evgRequestReady grant out; evgEventCode/IsK/GrantValid/GrantIndex registered slot outputs;
//        evgCollisionCount saturating counter with synchronous evgCollisionClear.
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int COMMA_INTERVAL  = 8,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                                         evgTxClk,
    input  logic                                         evgTxReset,
    input  logic [REQUESTER_COUNT-1:0]                   evgRequestEnable,
    input  logic [REQUESTER_COUNT-1:0]                   evgRequestValid,
    input  logic [EVENT_CODE_WIDTH*REQUESTER_COUNT-1:0]  evgRequestCode,
    output logic [REQUESTER_COUNT-1:0]                   evgRequestReady,
    output logic [EVENT_CODE_WIDTH-1:0]                  evgEventCode,
    output logic                                         evgEventIsK,
    output logic                                         evgGrantValid,
    output logic [evg_idx_width(REQUESTER_COUNT)-1:0]    evgGrantIndex,
    output logic [COUNTER_WIDTH-1:0]                     evgCollisionCount,
    input  logic                                         evgCollisionClear
);

    localparam int N     = REQUESTER_COUNT;
    localparam int IDX_W = evg_idx_width(N);
    localparam int CNT_W = evg_idx_width(COMMA_INTERVAL);

    logic [CNT_W-1:0]            r_comma_cnt;
    logic [IDX_W-1:0]            r_rr_ptr;
    logic [EVENT_CODE_WIDTH-1:0] r_code;
    logic                        r_is_k;
    logic                        r_gnt_vld;
    logic [IDX_W-1:0]            r_gnt_idx;
    logic [COUNTER_WIDTH-1:0]    r_coll_cnt;

    logic [N-1:0]                w_elig;
    logic                        w_comma;
    logic [N-2:0]                w_rr_grant;
    logic [IDX_W-1:0]            w_rr_idx;
    logic                        w_rr_vld;
    logic [N-1:0]                w_grant;
    logic [IDX_W-1:0]            w_win_idx;
    logic                        w_win_vld;
    logic                        w_rr_won;
    logic [EVENT_CODE_WIDTH-1:0] w_win_code;
    logic                        w_collide;

    assign w_elig  = evgRequestEnable & evgRequestValid;
    assign w_comma = (r_comma_cnt == '0);

    evg_rr_arbiter #(
        .N (N)
    ) u_rr (
        .i_req   (w_elig[N-1:1]),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_vld   (w_rr_vld)
    );

    // Comma slots suppress every grant; otherwise port 0 pre-empts the ring.
    always_comb begin
        w_grant   = '0;
        w_win_idx = '0;
        w_win_vld = 1'b0;
        w_rr_won  = 1'b0;
        if (!w_comma) begin
            if (w_elig[0]) begin
                w_grant[0] = 1'b1;
                w_win_vld  = 1'b1;
            end else if (w_rr_vld) begin
                w_grant   = {w_rr_grant, 1'b0};
                w_win_idx = w_rr_idx;
                w_win_vld = 1'b1;
                w_rr_won  = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_code = NULL_EVENT;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i])
                w_win_code = evgRequestCode[i*EVENT_CODE_WIDTH +: EVENT_CODE_WIDTH];
        end
    end

    // An eligible port goes unserved when the slot is a comma, or when more
    // than one port is eligible (x & (x-1) is non-zero for >=2 bits set).
    assign w_collide = (w_comma && (|w_elig)) || (|(w_elig & (w_elig - 1'b1)));

    // Ready must fall with reset even before any clock edge.
    assign evgRequestReady = evgTxReset ? '0 : w_grant;

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            r_comma_cnt <= CNT_W'(COMMA_INTERVAL - 1);
            r_rr_ptr    <= IDX_W'(1);
            r_code      <= NULL_EVENT;
            r_is_k      <= 1'b0;
            r_gnt_vld   <= 1'b0;
            r_gnt_idx   <= '0;
            r_coll_cnt  <= '0;
        end else begin
            r_comma_cnt <= w_comma ? CNT_W'(COMMA_INTERVAL - 1) : r_comma_cnt - 1'b1;

            if (w_rr_won)
                r_rr_ptr <= (w_rr_idx == IDX_W'(N - 1)) ? IDX_W'(1) : w_rr_idx + 1'b1;

            if (w_comma) begin
                r_code    <= K28_5;
                r_is_k    <= 1'b1;
                r_gnt_vld <= 1'b0;
                r_gnt_idx <= '0;
            end else begin
                r_code    <= w_win_vld ? w_win_code : NULL_EVENT;
                r_is_k    <= 1'b0;
                r_gnt_vld <= w_win_vld;
                r_gnt_idx <= w_win_idx;
            end

            if (evgCollisionClear)
                r_coll_cnt <= '0;
            else if (w_collide && (r_coll_cnt != '1))
                r_coll_cnt <= r_coll_cnt + 1'b1;
        end
    end

    assign evgEventCode      = r_code;
    assign evgEventIsK       = r_is_k;
    assign evgGrantValid     = r_gnt_vld;
    assign evgGrantIndex     = r_gnt_idx;
    assign evgCollisionCount = r_coll_cnt;

endmodule

// File: doc/evg_event_arbiter.md
Name: evg_event_arbiter

Overview:
Per-cycle scheduler for the event-code byte of the EVG transmit stream, in the evgTxClk domain. Several event sources share the single event slot per TX clock: heartbeat, sequencer, hardware triggers and software triggers. The block grants one source per cycle and forces a K28.5 comma at a fixed interval. It drives the event byte and K flag that the transmit path merges with the distributed-bus byte.

Parameters:
REQUESTER_COUNT, 4, number of request ports (>=2); port 0 has strict priority, ports 1..N-1 share round-robin.
COMMA_INTERVAL, 8, cycles between forced comma slots (>=2).
COUNTER_WIDTH, 16, width of the saturating collision counter.

Ports:
evgTxClk  input  1  transmit clock; sole clock of the block.
evgTxReset  input  1  asynchronous, active-high reset.
evgRequestEnable  input  N  per-port enable; a disabled port is never granted and its ready stays 0.
evgRequestValid  input  N  per-port request.
evgRequestCode  input  8*N  event code; port i occupies bits [8i+7:8i].
evgRequestReady  output  N  one-hot grant, asserted in the cycle the code is accepted.
evgEventCode  output  8  registered event byte.
evgEventIsK  output  1  registered K flag for evgEventCode.
evgGrantValid  output  1  registered; 1 when evgEventCode carries a granted event.
evgGrantIndex  output  clog2(N)  registered index of the granted port.
evgCollisionCount  output  COUNTER_WIDTH  saturating count of cycles with unserved valid requests.
evgCollisionClear  input  1  synchronous clear of evgCollisionCount.

Behaviour:
- Reset values:
  - evgEventCode=0x00, evgEventIsK=0, evgGrantValid=0, evgGrantIndex=0.
  - evgCollisionCount=0, round-robin pointer=1, comma counter=COMMA_INTERVAL-1.
  - While reset is asserted, evgRequestReady=0 (combinationally gated).
- Comma counter:
  - Decrements every cycle.
  - At 0 the cycle is a comma slot: the counter reloads to COMMA_INTERVAL-1, no port is granted, and the next-edge outputs are 0xBC, IsK=1, GrantValid=0.
  - Result: a comma every COMMA_INTERVAL cycles exactly, independent of request load.
- Non-comma slot, grant selection:
  - An eligible port has Enable&Valid.
  - If port 0 is eligible, it wins.
  - Otherwise, the first eligible port in 1..N-1 searching from the pointer upward with wrap wins.
- Ready and output timing:
  - evgRequestReady[winner]=1 combinationally in the same cycle.
  - On the next edge: evgEventCode=code, IsK=0, GrantValid=1, GrantIndex=winner.
  - Latency is 1 cycle from accepted request to output.
- Pointer update: after a grant to port k>=1, pointer=k+1, wrapping N to 1. A grant to port 0 leaves the pointer unchanged.
- No eligible port (non-comma slot): output 0x00, IsK=0, GrantValid=0.
- Handshake:
  - A source holds Valid and Code stable until Ready; there is no retraction requirement.
  - Code 0x00 is legal; it is granted and transmitted like any other code.
  - A port granted a single-cycle request may re-request immediately; back-to-back grants to the same port are allowed when it is the only eligible port.
- Collision counter:
  - Increments by 1 in any cycle where an eligible port is left ungranted: comma slot with >=1 eligible port, or >=2 eligible ports.
  - Saturates at all-ones.
  - Clear has priority over increment.
- Enable dropping while Valid is held: the port becomes ineligible that cycle; no partial state is kept.
- Asynchronous reset mid-stream: all state returns to reset values immediately. The first comma appears COMMA_INTERVAL cycles after release.

Decomposition:
- Shared package evg_pkg:
  - EVENT_CODE_WIDTH=8.
  - K28_5=8'hBC.
  - NULL_EVENT=8'h00.
  - Helper function for index width, clog2 with minimum 1.
- One sub-module, evg_rr_arbiter:
  - Combinational round-robin over ports 1..N-1: request vector and pointer in, one-hot grant and index out.
  - Pointer register lives in the parent.

Test Plan:
- Idle after reset (N=4, COMMA_INTERVAL=8), no requests: outputs 0x00/IsK=0 for 7 cycles, then 0xBC/IsK=1, repeating every 8 cycles; collision count stays 0.
- Port 2 requests 0x7A in a non-comma cycle: Ready[2]=1 the same cycle; next cycle Code=0x7A, GrantValid=1, GrantIndex=2.
- Ports 0 (0x11) and 1 (0x22) valid together: 0x11 output first, 0x22 on the following cycle; collision count=1.
- Ports 1, 2 and 3 valid continuously for 16 cycles: grant order 1,2,3,1,... with comma slots interleaved at 8-cycle spacing and the rotation unbroken across them; collision count increments every cycle.
- Port 3 valid only in the comma-slot cycle: Ready[3]=0, output 0xBC/IsK=1, collision count +1; port 3 is granted in the next cycle.
- Reset asserted mid-stream with port 1 valid: Ready drops with no clock edge, outputs are 0x00/IsK=0/count 0. After release the first comma appears at cycle 8. Separately, the count clears on evgCollisionClear even when an increment occurs in the same cycle.
